clock_divider_multi: RTL

//  Runtime-programmable N-channel clock divider / enable generator. Each channel divides

---
 rtl/clkdiv_pkg.sv | 32 +++
 rtl/clkdiv_channel.sv | 97 +++++++++
 rtl/clock_divider_multi.sv | 91 +++++++++
 3 files changed

// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clkdiv_pkg
//  Purpose  : Shared constants and config legality check for clock_divider_multi.
//  Revision : 1.0 - initial release
// ============================================================================
package clkdiv_pkg;

    localparam int c_WIDTH           = 28;
    localparam int c_DEFAULT_DIVISOR = 9090909;
    localparam int c_MAX_CHANNELS    = 16;
    localparam int c_MAX_CH_IDX_W    = $clog2(c_MAX_CHANNELS);

    // A single channel still needs a one-bit select port.
    function automatic int ch_idx_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // Arguments are zero-extended to 32 bits by the caller; only compares are done.
    function automatic logic cfg_legal(input logic [31:0] divisor,
                                       input logic [31:0] high,
                                       input logic        duty_en);
        logic ok;
        ok = (divisor >= 32'd2);
        if (duty_en) begin
            ok = ok && (high != 32'd0) && (high < divisor);
        end
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clkdiv_channel.sv
`default_nettype none
// ============================================================================
//  Module   : clkdiv_channel
//  Purpose  : One divider channel: counter, shadow config and pending flag.
//  Revision : 1.0 - initial release
// ============================================================================
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int WIDTH           = c_WIDTH,
    parameter int DEFAULT_DIVISOR = c_DEFAULT_DIVISOR
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic [WIDTH-1:0] cfg_high,
    output logic             clock_out,
    output logic             tick,
    output logic             pending
);

    localparam logic [WIDTH-1:0] c_RST_DIV  = WIDTH'(DEFAULT_DIVISOR);
    localparam logic [WIDTH-1:0] c_RST_HIGH = WIDTH'(DEFAULT_DIVISOR >> 1);

    logic [WIDTH-1:0] r_cnt_q,   w_cnt_d;
    logic [WIDTH-1:0] r_div_q,   w_div_d;
    logic [WIDTH-1:0] r_high_q,  w_high_d;
    logic [WIDTH-1:0] r_sdiv_q,  w_sdiv_d;
    logic [WIDTH-1:0] r_shigh_q, w_shigh_d;
    logic             r_pend_q,  w_pend_d;
    logic             r_clk_q,   w_clk_d;
    logic             r_tick_q,  w_tick_d;
    logic [WIDTH-1:0] w_last_cnt;
    logic             w_wrap;
    logic             w_apply_pt;

    always_comb begin
        w_last_cnt = r_div_q - WIDTH'(1);
        // >= rather than == so a shrunken divisor can never strand the counter.
        w_wrap     = (r_cnt_q >= w_last_cnt);
        // A disabled channel sits at cnt=0, so it is also a safe point to apply.
        w_apply_pt = !enable || w_wrap;

        w_cnt_d  = (enable && !w_wrap) ? r_cnt_q + WIDTH'(1) : '0;
        w_clk_d  = enable && (r_cnt_q < r_high_q);
        w_tick_d = enable && (r_cnt_q == w_last_cnt);

        w_div_d   = r_div_q;
        w_high_d  = r_high_q;
        w_sdiv_d  = r_sdiv_q;
        w_shigh_d = r_shigh_q;
        w_pend_d  = r_pend_q;

        if (cfg_we && enable) begin
            w_sdiv_d  = cfg_div;
            w_shigh_d = cfg_high;
            w_pend_d  = 1'b1;
        end else if (cfg_we) begin
            w_div_d  = cfg_div;
            w_high_d = cfg_high;
        end else if (r_pend_q && w_apply_pt) begin
            w_div_d  = r_sdiv_q;
            w_high_d = r_shigh_q;
            w_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_cnt_q   <= '0;
            r_div_q   <= c_RST_DIV;
            r_high_q  <= c_RST_HIGH;
            r_sdiv_q  <= c_RST_DIV;
            r_shigh_q <= c_RST_HIGH;
            r_pend_q  <= 1'b0;
            r_clk_q   <= 1'b0;
            r_tick_q  <= 1'b0;
        end else begin
            r_cnt_q   <= w_cnt_d;
            r_div_q   <= w_div_d;
            r_high_q  <= w_high_d;
            r_sdiv_q  <= w_sdiv_d;
            r_shigh_q <= w_shigh_d;
            r_pend_q  <= w_pend_d;
            r_clk_q   <= w_clk_d;
            r_tick_q  <= w_tick_d;
        end
    end

    assign clock_out = r_clk_q;
    assign tick      = r_tick_q;
    assign pending   = r_pend_q;

endmodule
`default_nettype wire

// File: rtl/clock_divider_multi.sv
`default_nettype none
// ============================================================================
//  Module   : clock_divider_multi
//  Purpose  : N-channel programmable clock divider / tick generator.
//             Define DUTY_CTRL_EN to add the load_high programmable-duty port.
//  Revision : 1.0 - initial release
// ============================================================================
module clock_divider_multi
    import clkdiv_pkg::*;
#(
    parameter  int CHANNELS        = 4,
    parameter  int WIDTH           = c_WIDTH,
    parameter  int DEFAULT_DIVISOR = c_DEFAULT_DIVISOR,
    localparam int c_IDX_W         = ch_idx_width(CHANNELS)
) (
    input  logic                clock_in,
    input  logic                reset,
    input  logic [CHANNELS-1:0] enable,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [c_IDX_W-1:0]  load_channel,
    input  logic [WIDTH-1:0]    load_divisor,
`ifdef DUTY_CTRL_EN
    input  logic [WIDTH-1:0]    load_high,
`endif
    output logic                load_error,
    output logic [CHANNELS-1:0] clock_out,
    output logic [CHANNELS-1:0] tick
);

    // WIDTH is limited to 32 bits by the legality check's argument width.
    logic [CHANNELS-1:0] w_pending;
    logic                w_ready;
    logic                w_accept;
    logic                w_legal;
    logic [WIDTH-1:0]    w_high;
    logic                r_load_error_q, w_load_error_d;

    always_comb begin
        w_ready = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (load_channel == c_IDX_W'(i)) begin
                w_ready = !w_pending[i];
            end
        end
    end

    always_comb begin
`ifdef DUTY_CTRL_EN
        w_high  = load_high;
        w_legal = cfg_legal(32'(load_divisor), 32'(load_high), 1'b1);
`else
        w_high  = load_divisor >> 1;
        w_legal = cfg_legal(32'(load_divisor), 32'd0, 1'b0);
`endif
        w_accept       = load_valid && w_ready;
        w_load_error_d = w_accept && !w_legal;
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_load_error_q <= 1'b0;
        end else begin
            r_load_error_q <= w_load_error_d;
        end
    end

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            clkdiv_channel #(
                .WIDTH           (WIDTH),
                .DEFAULT_DIVISOR (DEFAULT_DIVISOR)
            ) u_ch (
                .clock_in  (clock_in),
                .reset     (reset),
                .enable    (enable[i]),
                .cfg_we    (w_accept && w_legal && (load_channel == c_IDX_W'(i))),
                .cfg_div   (load_divisor),
                .cfg_high  (w_high),
                .clock_out (clock_out[i]),
                .tick      (tick[i]),
                .pending   (w_pending[i])
            );
        end
    endgenerate

    assign load_ready = w_ready;
    assign load_error = r_load_error_q;

endmodule
`default_nettype wire
